// File: rtl/out_hex_uart.sv
// Word FIFO feeding an 8N1 UART that prints each 16-bit word as four
// uppercase hex digits followed by CR LF.
module out_hex_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] out_data,
    input  logic        out_valid,
    output logic        out_ready,
    output logic        txd,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          ovf_q;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    char_q, char_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          txd_q, txd_d;
    logic [2:0]    bit_nx;
    logic          baud_last;
    logic [3:0]    nib;
    logic [7:0]    cur_char;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign push      = out_valid && !full;
    assign out_ready = !full;
    assign overflow  = ovf_q;
    assign txd       = txd_q;
    assign busy      = (state_q != IDLE);
    assign bit_nx    = bit_q + 3'd1;
    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (out_valid && full) ovf_q <= 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= out_data;
    end

    always_comb begin
        nib = 4'h0;
        unique case (char_q)
            3'd0:    nib = shadow_q[15:12];
            3'd1:    nib = shadow_q[11:8];
            3'd2:    nib = shadow_q[7:4];
            3'd3:    nib = shadow_q[3:0];
            default: nib = 4'h0;
        endcase
    end

    always_comb begin
        cur_char = 8'h0A;
        unique case (1'b1)
            (char_q < 3'd4): begin
                if (nib < 4'd10) cur_char = 8'h30 + {4'h0, nib};
                else             cur_char = 8'h37 + {4'h0, nib};
            end
            (char_q == 3'd4): cur_char = 8'h0D;
            default:          cur_char = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            char_q   <= '0;
            shadow_q <= '0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            char_q   <= char_d;
            shadow_q <= shadow_d;
            txd_q    <= txd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        char_d   = char_q;
        shadow_d = shadow_q;
        txd_d    = txd_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop      = 1'b1;
                    shadow_d = mem[rd_ptr];
                    state_d  = START;
                    txd_d    = 1'b0;
                    baud_d   = '0;
                    bit_d    = '0;
                    char_d   = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = cur_char[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_nx;
                        txd_d = cur_char[bit_nx];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    bit_d  = '0;
                    // LF done: drop to IDLE so words are separated by a cycle.
                    if (char_q == 3'd5) begin
                        state_d = IDLE;
                        char_d  = '0;
                        txd_d   = 1'b1;
                    end else begin
                        char_d  = char_q + 3'd1;
                        state_d = START;
                        txd_d   = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_out_hex_uart.sv
// Scoreboard bench for out_hex_uart: a bit-level UART receiver decodes txd
// and its characters are checked against words pushed into an expect queue.
module tb_out_hex_uart;

    localparam int CPB = 4;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] out_data = '0;
    logic        out_valid = 1'b0;
    logic        out_ready;
    logic        txd;
    logic        busy;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];

    logic       rx_act = 1'b0;
    int         rx_off = 0;
    logic [7:0] rx_sh = '0;

    out_hex_uart #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .txd      (txd),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Receiver: offsets count negedges after the first low sample.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (txd === 1'b0) begin
                rx_act <= 1'b1;
                rx_off <= 1;
            end
        end else begin
            rx_off <= rx_off + 1;
            if (rx_off == 2 && txd !== 1'b0) rx_act <= 1'b0;
            if (rx_off >= 6 && rx_off <= 34 && (rx_off - 6) % 4 == 0)
                rx_sh <= {txd, rx_sh[7:1]};
            if (rx_off == 38) begin
                rx_q.push_back({~txd, rx_sh});
                rx_act <= 1'b0;
            end
        end
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string h;
        h = "0123456789ABCDEF";
        return h[n];
    endfunction

    task automatic expect_word(input logic [15:0] w);
        exp_q.push_back({1'b0, hexc(w[15:12])});
        exp_q.push_back({1'b0, hexc(w[11:8])});
        exp_q.push_back({1'b0, hexc(w[7:4])});
        exp_q.push_back({1'b0, hexc(w[3:0])});
        exp_q.push_back(9'h00D);
        exp_q.push_back(9'h00A);
    endtask

    task automatic do_reset();
        out_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic push_word(input logic [15:0] w);
        out_data  = w;
        out_valid = 1'b1;
        @(posedge clk);
        #1 out_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd got %b want 1", txd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_cmp++; if (out_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", out_ready); end
        do_reset();
    endtask

    task automatic test_single();
        int bc;
        logic [8:0] g, e;
        do_reset();
        expect_word(16'h1A2F);
        push_word(16'h1A2F);
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL single_txd_e0 got %b want 1", txd); end
        @(posedge clk); #1;
        n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL single_txd_e1 got %b want 0", txd); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_e1 got %b want 1", busy); end
        bc = 0;
        @(negedge clk);
        while (busy === 1'b1 && bc < 1000) begin bc++; @(negedge clk); end
        n_cmp++; if (bc != 60 * CPB) begin n_bad++; $display("FAIL single_busy_len got %0d want %0d", bc, 60 * CPB); end
        wait_rx(6, 200);
        n_cmp++; if (rx_q.size() < 6) begin n_bad++; $display("FAIL single_timeout got %0d chars want 6", rx_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL single_char got %h want %h", g, e); end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL single_ovf got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        int bc, idle;
        logic [8:0] g, e;
        do_reset();
        expect_word(16'hFFFF);
        expect_word(16'h0000);
        push_word(16'hFFFF);
        repeat (2) @(posedge clk);
        out_data = 16'h0000; out_valid = 1'b1;
        @(posedge clk); #1 out_valid = 1'b0;
        bc = 0;
        @(negedge clk);
        while (busy === 1'b1 && bc < 400) begin bc++; @(negedge clk); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_first_end busy %b want 0", busy); end
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_txd got %b want 1", txd); end
        idle = 0;
        while (busy === 1'b0 && idle < 20) begin idle++; @(negedge clk); end
        n_cmp++; if (idle != 1) begin n_bad++; $display("FAIL b2b_idle got %0d want 1", idle); end
        wait_rx(12, 400);
        n_cmp++; if (rx_q.size() < 12) begin n_bad++; $display("FAIL b2b_timeout got %0d chars want 12", rx_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_char got %h want %h", g, e); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] w [6];
        logic [8:0] g, e;
        int t;
        w = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h5A5A, 16'hDEAD};
        do_reset();
        for (int i = 0; i < 5; i++) expect_word(w[i]);
        for (int i = 0; i < 6; i++) begin
            out_data = w[i]; out_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 3) begin
                n_cmp++; if (out_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_ready_e3 got %b want 1", out_ready); end
            end
            if (i == 4) begin
                n_cmp++; if (out_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready_e4 got %b want 0", out_ready); end
                n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_flag_e4 got %b want 0", overflow); end
            end
        end
        out_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag_e5 got %b want 1", overflow); end
        wait_rx(30, 1600);
        n_cmp++; if (rx_q.size() < 30) begin n_bad++; $display("FAIL ovf_timeout got %0d chars want 30", rx_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL ovf_char got %h want %h", g, e); end
        end
        t = 0;
        while (busy === 1'b1 && t < 100) begin t++; @(negedge clk); end
        repeat (60) @(negedge clk);
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL ovf_extra got %0d chars want 0", rx_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf_idle_busy got %b want 0", busy); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_held got %b want 1", overflow); end
    endtask

    task automatic test_full_pop();
        logic [8:0] g, e;
        int ed, t;
        do_reset();
        for (int i = 1; i <= 5; i++) expect_word(16'h1111 * i[15:0]);
        for (int i = 1; i <= 5; i++) begin
            out_data = 16'h1111 * i[15:0]; out_valid = 1'b1;
            @(posedge clk); #1;
        end
        out_data = 16'hBEEF;
        ed = 5;
        while (ed < 400) begin
            @(posedge clk); #1;
            if (out_ready === 1'b1) break;
            ed++;
        end
        out_valid = 1'b0;
        n_cmp++; if (ed != 242) begin n_bad++; $display("FAIL fullpop_edge got %0d want 242", ed); end
        wait_rx(30, 1600);
        n_cmp++; if (rx_q.size() < 30) begin n_bad++; $display("FAIL fullpop_timeout got %0d chars want 30", rx_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL fullpop_char got %h want %h", g, e); end
        end
        t = 0;
        while (busy === 1'b1 && t < 100) begin t++; @(negedge clk); end
        repeat (60) @(negedge clk);
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL fullpop_extra got %0d chars want 0", rx_q.size()); end
    endtask

    task automatic test_reset_midframe();
        logic [8:0] g, e;
        int lows;
        do_reset();
        exp_q.push_back({1'b0, hexc(4'h1)});
        exp_q.push_back({1'b0, hexc(4'hA)});
        push_word(16'h1A4F);
        repeat (91) @(posedge clk);
        #3;
        n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL mid_pre_txd got %b want 0", txd); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL mid_txd got %b want 1", txd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
        n_cmp++; if (out_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got %b want 1", out_ready); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) lows++;
        end
        n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL mid_quiet got %0d active cycles want 0", lows); end
        n_cmp++; if (rx_q.size() != 2) begin n_bad++; $display("FAIL mid_count got %0d chars want 2", rx_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL mid_char got %h want %h", g, e); end
        end
        rx_q.delete();
        exp_q.delete();
        expect_word(16'h00C3);
        @(posedge clk); #1;
        push_word(16'h00C3);
        @(posedge clk); #1;
        n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL post_txd_e1 got %b want 0", txd); end
        wait_rx(6, 400);
        n_cmp++; if (rx_q.size() < 6) begin n_bad++; $display("FAIL post_timeout got %0d chars want 6", rx_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL post_char got %h want %h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
